// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine with per-frame length and selectable bit order.
// Optional define SPI_LOOPBACK_EN adds a loopback input that feeds mosi into the rx path.
module spi_shift_engine #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              ss,
  input  logic              send_data,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              lsbfe,
  input  logic              cpha,
  input  logic              cpol,
  input  logic              flags_low,
  input  logic              flags_high,
  input  logic              flag_low,
  input  logic              flag_high,
  input  logic              receive_data,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              rx_valid,
  output logic              busy
);

  localparam logic [1:0]        IDLE  = 2'b00;
  localparam logic [1:0]        SHIFT = 2'b01;
  localparam logic [1:0]        DONE  = 2'b10;
  localparam logic [LEN_W-1:0]  ONE_L = LEN_W'(1);
  localparam logic [LEN_W-1:0]  MAX_L = LEN_W'(DATA_W);
  localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [DATA_W-1:0] tx_reg_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  tx_cnt_r;
  logic [LEN_W-1:0]  rx_cnt_r;

  logic              mode_s;
  logic              tx_stb_s;
  logic              rx_stb_s;
  logic              rx_bit_s;
  logic              tx_bit_s;
  logic [LEN_W-1:0]  load_len_s;
  logic [LEN_W-1:0]  tx_idx_s;
  logic [LEN_W-1:0]  rx_idx_s;
  logic [DATA_W-1:0] rx_mask_s;
  logic [DATA_W-1:0] rx_next_s;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit_s = loopback ? mosi : miso;
`else
  assign rx_bit_s = miso;
`endif

  // Strobe selection, effective length, bit positions and the next rx word
  always_comb begin
    mode_s   = cpha ^ cpol;
    tx_stb_s = mode_s ? flags_high : flags_low;
    rx_stb_s = (mode_s ? flag_high : flag_low) & receive_data;
    if ((frame_len == {LEN_W{1'b0}}) || (frame_len > MAX_L)) begin
      load_len_s = MAX_L;
    end else begin
      load_len_s = frame_len;
    end
    if (lsbfe) begin
      tx_idx_s = tx_cnt_r;
      rx_idx_s = rx_cnt_r;
    end else begin
      tx_idx_s = len_r - tx_cnt_r - ONE_L;
      rx_idx_s = len_r - rx_cnt_r - ONE_L;
    end
    // Mask-based select/insert keeps bit access free of index-width truncation
    tx_bit_s  = |(tx_reg_r & (ONE_D << tx_idx_s));
    rx_mask_s = ONE_D << rx_idx_s;
    rx_next_s = rx_bit_s ? (rx_shift_r | rx_mask_s) : (rx_shift_r & ~rx_mask_s);
  end

  // Frame FSM, shift registers, counters and registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= IDLE;
      tx_reg_r   <= {DATA_W{1'b0}};
      rx_shift_r <= {DATA_W{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      tx_cnt_r   <= {LEN_W{1'b0}};
      rx_cnt_r   <= {LEN_W{1'b0}};
      mosi       <= 1'b0;
      data_miso  <= {DATA_W{1'b0}};
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (send_data && !ss) begin
            tx_reg_r   <= data_mosi;
            len_r      <= load_len_s;
            tx_cnt_r   <= {LEN_W{1'b0}};
            rx_cnt_r   <= {LEN_W{1'b0}};
            rx_shift_r <= {DATA_W{1'b0}};
            busy       <= 1'b1;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss) begin
            tx_cnt_r <= {LEN_W{1'b0}};
            rx_cnt_r <= {LEN_W{1'b0}};
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            if (tx_stb_s && (tx_cnt_r < len_r)) begin
              mosi     <= tx_bit_s;
              tx_cnt_r <= tx_cnt_r + ONE_L;
            end
            if (rx_stb_s && (rx_cnt_r < len_r)) begin
              rx_shift_r <= rx_next_s;
              rx_cnt_r   <= rx_cnt_r + ONE_L;
              // Final bit: publish directly so rx_valid lands one PCLK after the strobe
              if ((rx_cnt_r + ONE_L) == len_r) begin
                data_miso <= rx_next_s;
                rx_valid  <= 1'b1;
                busy      <= 1'b0;
                state_r   <= DONE;
              end
            end
          end
        end
        DONE: begin
          tx_cnt_r <= {LEN_W{1'b0}};
          rx_cnt_r <= {LEN_W{1'b0}};
          state_r  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
